// File: rtl/wb_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_pkg
// Purpose  : Opcodes, response codes and FSM encodings for wb_cmd_master.
// Revision : 1.0  initial release
// ============================================================================
package wb_cmd_pkg;

    localparam logic [1:0] CMD_SETADDR = 2'b00;
    localparam logic [1:0] CMD_WRITE   = 2'b01;
    localparam logic [1:0] CMD_READ    = 2'b10;
    localparam logic [1:0] CMD_RSVD    = 2'b11;

    localparam logic [1:0] RSP_ADDR    = 2'b00;
    localparam logic [1:0] RSP_WACK    = 2'b01;
    localparam logic [1:0] RSP_RDATA   = 2'b10;
    localparam logic [1:0] RSP_ERR     = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQ      = 2'd1;
    localparam logic [1:0] ST_WAIT     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Purpose  : Executes 34-bit command words as single pipelined Wishbone
//            transactions and returns one response word per command.
// Revision : 1.0  initial release
// ============================================================================
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_stb,
    input  logic [33:0] cmd_word,
    output logic        cmd_busy,
    output logic        rsp_stb,
    output logic [33:0] rsp_word,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [29:0] wb_addr,
    output logic [31:0] wb_data_o,
    output logic [3:0]  wb_sel,
    input  logic        wb_stall,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic [31:0] wb_data_i
);

    localparam logic [TW-1:0] c_TIMEOUT = TW'(TIMEOUT);

    logic [1:0]    r_state_q,    w_state_d;
    logic [29:0]   r_addr_q,     w_addr_d;
    logic          r_inc_q,      w_inc_d;
    logic [TW-1:0] r_timer_q,    w_timer_d;
    logic          r_cyc_q,      w_cyc_d;
    logic          r_stb_q,      w_stb_d;
    logic          r_we_q,       w_we_d;
    logic [29:0]   r_wb_addr_q,  w_wb_addr_d;
    logic [31:0]   r_wdata_q,    w_wdata_d;
    logic [3:0]    r_sel_q,      w_sel_d;
    logic          r_rsp_stb_q,  w_rsp_stb_d;
    logic [33:0]   r_rsp_word_q, w_rsp_word_d;

    logic [1:0]    w_op;
    logic [31:0]   w_payload;
    logic          w_done;
    logic          w_ok;

    assign w_op      = cmd_word[33:32];
    assign w_payload = cmd_word[31:0];

    always_comb begin
        w_state_d    = r_state_q;
        w_addr_d     = r_addr_q;
        w_inc_d      = r_inc_q;
        w_timer_d    = r_timer_q;
        w_cyc_d      = r_cyc_q;
        w_stb_d      = r_stb_q;
        w_we_d       = r_we_q;
        w_wb_addr_d  = r_wb_addr_q;
        w_wdata_d    = r_wdata_q;
        w_sel_d      = r_sel_q;
        w_rsp_stb_d  = 1'b0;
        w_rsp_word_d = r_rsp_word_q;
        w_done       = 1'b0;
        w_ok         = wb_ack & ~wb_err;

        case (r_state_q)
            ST_IDLE: begin
                if (cmd_stb) begin
                    case (w_op)
                        CMD_SETADDR: begin
                            w_addr_d     = w_payload[31:2];
                            w_inc_d      = w_payload[0];
                            w_rsp_stb_d  = 1'b1;
                            w_rsp_word_d = {RSP_ADDR, w_payload[31:2], 1'b0, w_payload[0]};
                        end
                        CMD_WRITE, CMD_READ: begin
                            w_state_d   = ST_REQ;
                            w_cyc_d     = 1'b1;
                            w_stb_d     = 1'b1;
                            w_we_d      = (w_op == CMD_WRITE);
                            w_wb_addr_d = r_addr_q;
                            w_sel_d     = 4'hF;
                            if (w_op == CMD_WRITE) begin
                                w_wdata_d = w_payload;
                            end
                        end
                        default: begin
                            w_rsp_stb_d  = 1'b1;
                            w_rsp_word_d = {RSP_ERR, r_addr_q, 2'b00};
                        end
                    endcase
                end
            end
            ST_REQ: begin
                // An ack/err arriving in the accepting cycle completes at once.
                if (!wb_stall) begin
                    w_stb_d   = 1'b0;
                    w_timer_d = '0;
                    w_state_d = ST_WAIT;
                    w_done    = wb_ack | wb_err;
                end
            end
            ST_WAIT: begin
                w_done = wb_ack | wb_err | (r_timer_q == c_TIMEOUT);
                if (!w_done) begin
                    w_timer_d = r_timer_q + TW'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cyc_d   = 1'b0;
                w_stb_d   = 1'b0;
            end
        endcase

        if (w_done) begin
            w_state_d   = ST_IDLE;
            w_cyc_d     = 1'b0;
            w_stb_d     = 1'b0;
            w_sel_d     = 4'h0;
            w_rsp_stb_d = 1'b1;
            if (w_ok) begin
                w_rsp_word_d = r_we_q ? {RSP_WACK, r_wb_addr_q, 2'b00}
                                      : {RSP_RDATA, wb_data_i};
                if (r_inc_q) begin
                    w_addr_d = r_addr_q + 30'd1;
                end
            end else begin
                w_rsp_word_d = {RSP_ERR, r_wb_addr_q, 2'b00};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_addr_q     <= '0;
            r_inc_q      <= 1'b0;
            r_timer_q    <= '0;
            r_cyc_q      <= 1'b0;
            r_stb_q      <= 1'b0;
            r_we_q       <= 1'b0;
            r_wb_addr_q  <= '0;
            r_wdata_q    <= '0;
            r_sel_q      <= '0;
            r_rsp_stb_q  <= 1'b0;
            r_rsp_word_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_addr_q     <= w_addr_d;
            r_inc_q      <= w_inc_d;
            r_timer_q    <= w_timer_d;
            r_cyc_q      <= w_cyc_d;
            r_stb_q      <= w_stb_d;
            r_we_q       <= w_we_d;
            r_wb_addr_q  <= w_wb_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_sel_q      <= w_sel_d;
            r_rsp_stb_q  <= w_rsp_stb_d;
            r_rsp_word_q <= w_rsp_word_d;
        end
    end

    assign cmd_busy  = (r_state_q != ST_IDLE);
    assign rsp_stb   = r_rsp_stb_q;
    assign rsp_word  = r_rsp_word_q;
    assign wb_cyc    = r_cyc_q;
    assign wb_stb    = r_stb_q;
    assign wb_we     = r_we_q;
    assign wb_addr   = r_wb_addr_q;
    assign wb_data_o = r_wdata_q;
    assign wb_sel    = r_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Purpose  : Self-checking bench for wb_cmd_master with a Wishbone slave model
//            and a command-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_cmd_master;

    localparam int c_TIMEOUT = 12;
    localparam int c_TW      = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_stb;
    logic [33:0] cmd_word;
    logic        cmd_busy;
    logic        rsp_stb;
    logic [33:0] rsp_word;
    logic        wb_cyc, wb_stb, wb_we;
    logic [29:0] wb_addr;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_sel;
    logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
    logic [31:0] wb_data_i = 32'h0;

    wb_cmd_master #(.TIMEOUT(c_TIMEOUT), .TW(c_TW)) u_dut (
        .clk(clk), .reset(reset), .cmd_stb(cmd_stb), .cmd_word(cmd_word),
        .cmd_busy(cmd_busy), .rsp_stb(rsp_stb), .rsp_word(rsp_word),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data_o(wb_data_o), .wb_sel(wb_sel), .wb_stall(wb_stall),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_data_i(wb_data_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Slave: 0 ack, 1 err, 2 err+ack, 3 silent; answers one cycle after acceptance.
    int          slv_mode    = 0;
    int          slv_stall_n = 0;
    int          stall_left  = 0;
    bit          force_ack   = 1'b0;
    bit          pend        = 1'b0;
    logic        p_we;
    logic [29:0] p_addr;
    logic [31:0] p_data;
    logic [31:0] slave_mem [logic [29:0]];

    always @(negedge clk) begin
        wb_ack    = 1'b0;
        wb_err    = 1'b0;
        wb_data_i = 32'h0;
        if (force_ack) wb_ack = 1'b1;
        if (pend) begin
            pend = 1'b0;
            case (slv_mode)
                0: begin
                    wb_ack = 1'b1;
                    if (p_we) slave_mem[p_addr] = p_data;
                    else wb_data_i = slave_mem.exists(p_addr) ? slave_mem[p_addr] : 32'h0;
                end
                1: wb_err = 1'b1;
                2: begin wb_err = 1'b1; wb_ack = 1'b1; end
                default: ;
            endcase
        end
        wb_stall = 1'b0;
        if (wb_cyc && wb_stb) begin
            if (stall_left > 0) begin
                wb_stall = 1'b1;
                stall_left--;
            end else begin
                pend   = 1'b1;
                p_we   = wb_we;
                p_addr = wb_addr;
                p_data = wb_data_o;
            end
        end
    end

    // Reference model: bus address/increment state and a word memory.
    logic [29:0] m_addr = 30'h0;
    logic        m_inc  = 1'b0;
    logic [31:0] model_mem [logic [29:0]];
    logic [33:0] exp_q [$];

    task automatic predict(input logic [1:0] op, input logic [31:0] p,
                           output logic [33:0] w, output int lat);
        if (op == 2'b00) begin
            m_addr = p[31:2];
            m_inc  = p[0];
            w      = {2'b00, m_addr, 1'b0, m_inc};
            lat    = 1;
        end else if (op == 2'b11) begin
            w   = {2'b11, m_addr, 2'b00};
            lat = 1;
        end else begin
            lat = 2 + slv_stall_n + ((slv_mode == 3) ? c_TIMEOUT + 1 : 1);
            if (slv_mode == 0) begin
                if (op == 2'b01) begin
                    model_mem[m_addr] = p;
                    w = {2'b01, m_addr, 2'b00};
                end else begin
                    w = {2'b10, model_mem.exists(m_addr) ? model_mem[m_addr] : 32'h0};
                end
                if (m_inc) m_addr = m_addr + 30'd1;
            end else begin
                w = {2'b11, m_addr, 2'b00};
            end
        end
    endtask

    // Per-cycle compare process.
    bit          run_chk = 1'b0;
    logic        edge_stall = 1'b0, edge_rst = 1'b0;
    logic        prev_stb = 1'b0, prev_we = 1'b0;
    logic [29:0] prev_addr = 30'h0;
    logic [31:0] prev_data = 32'h0;

    always @(posedge clk) begin
        edge_stall <= wb_stall;
        edge_rst   <= reset;
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("busy_vs_cyc", cmd_busy, wb_cyc);
            if (wb_stb) chk("sel_during_req", wb_sel, 4'hF);
            if (prev_stb && edge_stall && !edge_rst) begin
                chk("stall_stb_held", wb_stb, 1'b1);
                chk("stall_fields_held", {wb_we, wb_addr, wb_data_o}, {prev_we, prev_addr, prev_data});
            end
            if (exp_q.size() == 0) chk("rsp_spurious", rsp_stb, 1'b0);
            else if (rsp_stb) chk("rsp_word", rsp_word, exp_q.pop_front());
        end
        prev_stb  = wb_stb;
        prev_we   = wb_we;
        prev_addr = wb_addr;
        prev_data = wb_data_o;
    end

    // Per-command observations for literal checks.
    logic [33:0] last_rsp;
    logic        rsp_cyc;
    bit          saw_cyc;
    int          stb_cycles;
    bit          cap_valid;
    logic        cap_we;
    logic [29:0] cap_addr;
    logic [31:0] cap_data;
    logic [3:0]  cap_sel;

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] p, input bit inject);
        logic [33:0] w;
        int lat, n;
        bit got;
        predict(op, p, w, lat);
        stall_left = slv_stall_n;
        exp_q.push_back(w);
        @(negedge clk);
        chk("busy_before_cmd", cmd_busy, 1'b0);
        cmd_stb  = 1'b1;
        cmd_word = {op, p};
        n = 0; got = 1'b0; stb_cycles = 0; saw_cyc = 1'b0; cap_valid = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) cmd_stb = 1'b0;
            if (inject && n == 2) begin cmd_stb = 1'b1; cmd_word = {2'b11, 32'h0}; end
            if (inject && n == 3) cmd_stb = 1'b0;
            if (wb_cyc) saw_cyc = 1'b1;
            if (wb_stb) begin
                stb_cycles++;
                if (!cap_valid) begin
                    cap_valid = 1'b1;
                    cap_we = wb_we; cap_addr = wb_addr; cap_data = wb_data_o; cap_sel = wb_sel;
                end
            end
            if (rsp_stb) begin
                got      = 1'b1;
                last_rsp = rsp_word;
                rsp_cyc  = wb_cyc;
            end
        end
        chk("rsp_latency", n, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_stb = 1'b0; cmd_word = 34'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", cmd_busy, 1'b0);
        chk("rst_rsp_stb", rsp_stb, 1'b0);
        chk("rst_rsp_word", rsp_word, 34'h0);
        chk("rst_bus", {wb_cyc, wb_stb, wb_we, wb_sel}, 7'h0);
        chk("rst_addr_data", {wb_addr, wb_data_o}, 62'h0);
        reset = 1'b0;
        run_chk = 1'b1;

        // SETADDR and zero-wait write/read
        do_cmd(2'b00, 32'h0000_0100, 1'b0);
        chk("lit_setaddr", last_rsp, 34'h0_0000_0100);
        chk("setaddr_no_cyc", saw_cyc, 1'b0);
        do_cmd(2'b01, 32'hDEAD_BEEF, 1'b0);
        chk("lit_wr_fields", {cap_we, cap_addr, cap_sel, cap_data}, {1'b1, 30'h40, 4'hF, 32'hDEAD_BEEF});
        chk("lit_wr_rsp", last_rsp, 34'h1_0000_0100);
        do_cmd(2'b10, 32'h0, 1'b0);
        chk("lit_rd_rsp", last_rsp, 34'h2_DEAD_BEEF);

        // stalled write with an ignored command while busy
        slv_stall_n = 3;
        do_cmd(2'b01, 32'h1234_5678, 1'b1);
        chk("stall_stb_cycles", stb_cycles, 4);
        chk("lit_stall_rsp", last_rsp, 34'h1_0000_0100);
        slv_stall_n = 0;

        // auto-increment wrap
        do_cmd(2'b00, 32'hFFFF_FFF9, 1'b0);
        chk("lit_setaddr_inc", last_rsp, 34'h0_FFFF_FFF9);
        do_cmd(2'b01, 32'h1, 1'b0);
        chk("wrap_addr0", cap_addr, 30'h3FFF_FFFE);
        do_cmd(2'b01, 32'h2, 1'b0);
        chk("wrap_addr1", cap_addr, 30'h3FFF_FFFF);
        do_cmd(2'b01, 32'h3, 1'b0);
        chk("wrap_addr2", cap_addr, 30'h0);
        do_cmd(2'b10, 32'h0, 1'b0);
        chk("wrap_addr3", cap_addr, 30'h1);

        // error, err+ack, timeout, reserved opcode
        do_cmd(2'b00, 32'h0000_0201, 1'b0);
        slv_mode = 1;
        do_cmd(2'b10, 32'h0, 1'b0);
        chk("lit_err_rsp", last_rsp, 34'h3_0000_0200);
        slv_mode = 0;
        do_cmd(2'b01, 32'hCAFE_0001, 1'b0);
        chk("err_no_inc", cap_addr, 30'h80);
        slv_mode = 2;
        do_cmd(2'b10, 32'h0, 1'b0);
        chk("lit_errack_rsp", last_rsp, 34'h3_0000_0204);
        slv_mode = 0;
        do_cmd(2'b10, 32'h0, 1'b0);
        chk("errack_no_inc", cap_addr, 30'h81);
        slv_mode = 3;
        do_cmd(2'b01, 32'h5555_AAAA, 1'b0);
        chk("lit_tmo_rsp", last_rsp, 34'h3_0000_0208);
        chk("tmo_cyc_low", rsp_cyc, 1'b0);
        do_cmd(2'b11, 32'h0, 1'b0);
        chk("lit_rsvd_rsp", last_rsp, 34'h3_0000_0208);

        // reset while waiting on a silent slave
        @(negedge clk);
        cmd_stb = 1'b1; cmd_word = {2'b01, 32'h0BAD_0BAD};
        @(negedge clk);
        cmd_stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_in_wait", {wb_cyc, wb_stb}, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_cyc", wb_cyc, 1'b0);
        chk("midrst_busy", cmd_busy, 1'b0);
        m_addr = 30'h0; m_inc = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        slv_mode = 0;
        do_cmd(2'b01, 32'h0000_A5A5, 1'b0);
        chk("midrst_addr0", cap_addr, 30'h0);
        chk("lit_midrst_rsp", last_rsp, 34'h1_0000_0000);
        do_cmd(2'b01, 32'h0000_5A5A, 1'b0);
        chk("midrst_inc0", cap_addr, 30'h0);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Bus-master stage directly downstream of riscv_multi's command/response interface.
- Consumes 34-bit command words (cmd_stb/cmd_word/cmd_busy) and executes them as single Wishbone pipelined transactions.
- Returns one 34-bit response word per command (rsp_stb/rsp_word).
- Holds the current bus address, with optional auto-increment.

Parameters:
- TIMEOUT, 1023, max cycles to wait for ack/err once the request is accepted; must be >= 1.
- TW, 10, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- cmd_stb  input  1  command valid; ignored while cmd_busy=1.
- cmd_word  input  34  [33:32] opcode, [31:0] payload.
- cmd_busy  output  1  master cannot accept a command this cycle.
- rsp_stb  output  1  one-cycle response valid pulse.
- rsp_word  output  34  [33:32] response code, [31:0] payload.
- wb_cyc  output  1  bus cycle.
- wb_stb  output  1  request strobe.
- wb_we  output  1  1 = write.
- wb_addr  output  30  word address.
- wb_data_o  output  32  write data.
- wb_sel  output  4  byte enables, constant 4'hF during requests.
- wb_stall  input  1  slave stall.
- wb_ack  input  1  slave ack.
- wb_err  input  1  slave error.
- wb_data_i  input  32  read data.

Behaviour:
- Reset: synchronous, active-high; interface already decided as one clock (clk), sync active-high reset (reset).
  - Reset values: state=IDLE, cmd_busy=0, rsp_stb=0, rsp_word=0, wb_cyc=0, wb_stb=0, wb_we=0, wb_addr=0, wb_data_o=0, wb_sel=0.
  - Internal: addr=0, inc=0, timer=0.
- Opcodes:
  - 00 SETADDR: addr<=payload[31:2], inc<=payload[0]; no bus activity.
  - 01 WRITE: payload is write data.
  - 10 READ: payload ignored.
  - 11 reserved: error response.
- Response codes:
  - 00 addr ack: payload {addr,1'b0,inc}.
  - 01 write ack: payload {addr_used,2'b00}.
  - 10 read data: payload wb_data_i.
  - 11 error: payload {addr_used,2'b00}.
- FSM states IDLE, REQ, WAIT.
- IDLE:
  - cmd_stb with SETADDR or 11 → stay IDLE; rsp_stb=1 next cycle.
  - cmd_stb with WRITE/READ → REQ; wb_cyc=wb_stb=1, wb_we, wb_addr=addr, wb_data_o, wb_sel=F registered at the same edge.
- REQ:
  - wb_stall=1 → hold stb and all request fields stable.
  - wb_stall=0 → request accepted; stb<=0, timer<=0, go to WAIT.
  - wb_ack/wb_err sampled in the accepting cycle are honoured as in WAIT.
- WAIT:
  - On wb_err → IDLE, cyc<=0, error response.
  - Else on wb_ack → IDLE, cyc<=0, write ack or read data response.
  - wb_err and wb_ack together → err wins.
  - timer==TIMEOUT with no ack/err → IDLE, cyc<=0, error response.
  - Timer counts REQ-accepted cycles only; stall time is not counted.
- cmd_busy=1 whenever state!=IDLE; cmd_busy=0 in the cycle rsp_stb=1, so back-to-back commands are allowed.
- Latency:
  - SETADDR/11: rsp_stb 1 cycle after cmd_stb.
  - Zero-wait slave (ack the cycle after acceptance): rsp_stb 3 cycles after cmd_stb.
- Auto-increment: applies only on a successful ack with inc=1; addr<=addr+1 mod 2^30, so 0x3FFFFFFF wraps to 0. Error or timeout never increments.
- Spurious acks: wb_ack/wb_err while wb_cyc=0 are ignored.
- Reset mid-transaction: cyc/stb drop at that edge, no response is produced, addr=0.

Decomposition:
- Package wb_cmd_pkg holds:
  - opcode localparams CMD_SETADDR/CMD_WRITE/CMD_READ/CMD_RSVD;
  - response codes RSP_ADDR/RSP_WACK/RSP_RDATA/RSP_ERR;
  - state encodings ST_IDLE/ST_REQ/ST_WAIT.
- No sub-module needed. The timeout counter is inline (~15 lines); total RTL is ~150–200 lines.

Test Plan:
- SETADDR payload 0x00000100 → rsp_stb 1 cycle later, rsp_word={00,0x00000100}; wb_cyc stays 0 throughout.
- Zero-wait memory model: WRITE 0xDEADBEEF at addr 0x40, then READ → write shows wb_we=1, wb_addr=0x40, wb_sel=F, rsp {01,0x00000100}; read returns rsp {10,0xDEADBEEF}; each response arrives 3 cycles after cmd_stb.
- Slave asserts wb_stall for 3 cycles during a WRITE → wb_stb high for 4 cycles with wb_addr/wb_data_o/wb_we unchanged; cmd_stb issued while busy is ignored and produces no extra response.
- SETADDR 0xFFFFFFF9 (addr 0x3FFFFFFE, inc=1), then 3 WRITEs → wb_addr 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000; a subsequent SETADDR readback shows addr=1.
- Error paths:
  - Slave returns wb_err on a READ at 0x80 → rsp {11,0x00000200}, no increment.
  - Slave returns wb_err+wb_ack together → err response.
  - Silent slave → rsp {11,...} exactly TIMEOUT+1 cycles after acceptance, then wb_cyc=0.
  - Opcode 11 → immediate rsp {11,...}.
- Reset asserted while in WAIT → next cycle wb_cyc=0, cmd_busy=0, no rsp_stb even if wb_ack arrives afterwards; a SETADDR readback shows addr=0, inc=0.
